// File: rtl/odo_sbox_bank.sv
// rtl/odo_sbox_bank.sv - dual-bank runtime-loadable multi-lane S-box bank
// Optional permutation check enabled by defining ODO_SBOX_BANK_PERM_CHECK_EN.
module odo_sbox_bank #(
  parameter int WIDTH    = 6,
  parameter int LANES    = 4,
  parameter int OUT_PIPE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [WIDTH-1:0]       load_data,
  output logic                   load_ready,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   load_err,
  output logic                   table_valid,
  output logic                   bank_sel
);
  localparam int DEPTH = 2 ** WIDTH;
  localparam int AW    = WIDTH + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWAP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wr_en;
  logic              bank_sel_q;
  logic              table_valid_q;
  logic              swap_ok;
  logic [WIDTH-1:0]  mem_q [2][DEPTH];
  logic [LANES*WIDTH-1:0] lut_d;
  logic              s1_valid_q;
  logic [LANES*WIDTH-1:0] s1_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // load_start wins over a coincident beat so a restart never keeps stale data
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          addr_d  = '0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          addr_d = '0;
        end else if (load_valid) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_d = S_SWAP;
        end
      end
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_ready = (state_q == S_LOAD);
  assign load_busy  = (state_q == S_LOAD) || (state_q == S_SWAP);
  assign load_done  = (state_q == S_SWAP);

`ifdef ODO_SBOX_BANK_PERM_CHECK_EN
  logic [DEPTH-1:0] seen_q;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= '0;
      err_q  <= 1'b0;
    end else if (load_start && state_q != S_SWAP) begin
      seen_q <= '0;
      err_q  <= 1'b0;
    end else if (wr_en) begin
      seen_q[load_data] <= 1'b1;
      if (seen_q[load_data]) err_q <= 1'b1;
    end
  end

  assign load_err = err_q;
  assign swap_ok  = !err_q;
`else
  assign load_err = 1'b0;
  assign swap_ok  = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel_q    <= 1'b0;
      table_valid_q <= 1'b0;
    end else if (state_q == S_SWAP && swap_ok) begin
      bank_sel_q    <= ~bank_sel_q;
      table_valid_q <= 1'b1;
    end
  end

  assign bank_sel    = bank_sel_q;
  assign table_valid = table_valid_q;

  // Shadow writes always go to the inactive bank, so reads never collide
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[~bank_sel_q][addr_q[WIDTH-1:0]] <= load_data;
  end

  always_comb begin
    lut_d = '0;
    for (int k = 0; k < LANES; k++) begin
      lut_d[k*WIDTH +: WIDTH] = table_valid_q ? mem_q[bank_sel_q][in_data[k*WIDTH +: WIDTH]] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_data_q <= lut_d;
    end
  end

  generate
    if (OUT_PIPE == 1) begin : g_pipe
      logic                   s2_valid_q;
      logic [LANES*WIDTH-1:0] s2_data_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          s2_data_q  <= s1_data_q;
        end
      end
      assign out_valid = s2_valid_q;
      assign out_data  = s2_data_q;
    end else begin : g_nopipe
      assign out_valid = s1_valid_q;
      assign out_data  = s1_data_q;
    end
  endgenerate
endmodule

// File: tb/tb_odo_sbox_bank.sv
// tb/tb_odo_sbox_bank.sv - randomized self-checking bench for odo_sbox_bank
// Honours ODO_SBOX_BANK_PERM_CHECK_EN in both the model and the directed checks.
module tb_odo_sbox_bank #(parameter int OUT_PIPE = 0);
  localparam int W = 6;
  localparam int L = 4;
  localparam int D = 64;
  localparam int LAT = 1 + OUT_PIPE;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [L*W-1:0] in_data;
  logic out_valid;
  logic [L*W-1:0] out_data;
  logic load_start, load_valid;
  logic [W-1:0] load_data;
  logic load_ready, load_busy, load_done, load_err, table_valid, bank_sel;

  odo_sbox_bank #(.WIDTH(W), .LANES(L), .OUT_PIPE(OUT_PIPE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .table_valid(table_valid), .bank_sel(bank_sel)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int done_seen = 0;
  bit chk_en = 0;
  bit rand_lk = 0;
  logic [W-1:0] tbl [D];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the active table is a plain array copied wholesale on a swap
  logic [W-1:0] m_act [D];
  logic [W-1:0] m_shadow [D];
  logic [D-1:0] m_seen;
  bit m_sel, m_tv, m_ld, m_swap, m_err;
  int m_cnt;
  logic p_v [LAT] = '{default: 1'b0};
  logic [L*W-1:0] p_d [LAT] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sel = 0; m_tv = 0; m_ld = 0; m_swap = 0; m_err = 0; m_cnt = 0;
      for (int i = 0; i < LAT; i++) begin p_v[i] = 1'b0; p_d[i] = '0; end
    end else begin
      logic [L*W-1:0] nd;
      nd = '0;
      for (int k = 0; k < L; k++)
        nd[k*W +: W] = m_tv ? m_act[in_data[k*W +: W]] : '0;
      for (int i = LAT - 1; i > 0; i--) begin p_v[i] = p_v[i-1]; p_d[i] = p_d[i-1]; end
      p_v[0] = in_valid;
      p_d[0] = nd;
      if (m_swap) begin
        m_swap = 0;
        if (!m_err) begin m_act = m_shadow; m_sel = !m_sel; m_tv = 1; end
      end else if (load_start) begin
        m_ld = 1; m_cnt = 0; m_err = 0; m_seen = '0;
      end else if (m_ld && load_valid) begin
        m_shadow[m_cnt] = load_data;
`ifdef ODO_SBOX_BANK_PERM_CHECK_EN
        if (m_seen[load_data]) m_err = 1;
        m_seen[load_data] = 1'b1;
`endif
        m_cnt++;
        if (m_cnt == D) begin m_ld = 0; m_swap = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, p_v[LAT-1]);
      if (p_v[LAT-1]) chk("out_data", out_data, p_d[LAT-1]);
      chk("load_ready", load_ready, m_ld);
      chk("load_busy", load_busy, m_ld | m_swap);
      chk("load_done", load_done, m_swap);
      chk("load_err", load_err, m_err);
      chk("table_valid", table_valid, m_tv);
      chk("bank_sel", bank_sel, m_sel);
      if (load_done) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_lk) begin
      in_valid = ($urandom_range(3, 0) != 0);
      in_data  = L*W'($urandom);
    end
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    load_start = 1; tick(); load_start = 0;
  endtask

  task automatic beats(input int first, input int n, input bit gap);
    for (int i = first; i < first + n; i++) begin
      load_valid = 1; load_data = tbl[i]; tick();
      if (gap) begin load_valid = 0; load_data = W'($urandom); tick(); end
    end
    load_valid = 0;
  endtask

  task automatic load_table(input bit gap);
    pulse_start();
    beats(0, D, gap);
    tick();
  endtask

  task automatic fill_perm();
    for (int i = 0; i < D; i++) tbl[i] = W'(i);
    for (int i = D - 1; i > 0; i--) begin
      int j;
      logic [W-1:0] t;
      j = $urandom_range(i, 0);
      t = tbl[i]; tbl[i] = tbl[j]; tbl[j] = t;
    end
  endtask

  initial begin
    int bs;
    rst = 1; in_valid = 0; in_data = '0;
    load_start = 0; load_valid = 0; load_data = '0;
    tickn(3);
    rst = 0;
    chk_en = 1;
    chk("rst_table_valid", table_valid, 0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_load_busy", load_busy, 0);

    in_valid = 1; in_data = {L{6'h3F}};
    tickn(LAT);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 0);
    in_valid = 0;

    for (int i = 0; i < D; i++) tbl[i] = W'((i * 5 + 1) % 64);
    load_table(0);
    chk("t2_bank_sel", bank_sel, 1);
    chk("t2_done_once", done_seen, 1);
    in_valid = 1; in_data = {6'd63, 6'd2, 6'd1, 6'd0};
    tickn(LAT);
    chk("t2_lookup", out_data, {6'h3C, 6'h0B, 6'h06, 6'h01});

    in_data = {L{6'd10}};
    for (int i = 0; i < D; i++) tbl[i] = W'(63 - i);
    pulse_start();
    beats(0, 32, 0);
    chk("t3_old_bank", out_data, {L{6'h33}});
    beats(32, 32, 0);
    tick();
    tickn(LAT);
    chk("t3_new_bank", out_data, {L{6'h35}});
    chk("t3_done_twice", done_seen, 2);

    rand_lk = 1;
    fill_perm(); pulse_start(); beats(0, 40, 0);
    fill_perm(); load_table(0);
    chk("t4_restart_done", done_seen, 3);
    tickn(4);
    fill_perm(); pulse_start(); beats(0, 20, 0);
    rst = 1; #1;
    chk("t4_rst_bank_sel", bank_sel, 0);
    chk("t4_rst_busy", load_busy, 0);
    tick(); rst = 0;
    tickn(70);
    chk("t4_rst_no_done", done_seen, 3);

    fill_perm(); load_table(1);
    chk("t5_gap_done", done_seen, 4);
    chk("t5_gap_bank", bank_sel, 1);
    load_valid = 1;
    for (int i = 0; i < 10; i++) begin load_data = W'($urandom); tick(); end
    load_valid = 0;
    chk("t5_idle_bank", bank_sel, 1);
    chk("t5_idle_busy", load_busy, 0);

    fill_perm();
    bs = (tbl[0] == 6'd5) ? 1 : 0;
    tbl[bs] = 6'd5;
    load_table(0);
    tickn(2);
    chk("t6_done", done_seen, 5);
`ifdef ODO_SBOX_BANK_PERM_CHECK_EN
    chk("t6_err", load_err, 1);
    chk("t6_bank_kept", bank_sel, 1);
`else
    chk("t6_bank_swapped", bank_sel, 0);
`endif

    for (int n = 0; n < 3; n++) begin
      fill_perm();
      load_table(1'($urandom_range(1, 0)));
      tickn($urandom_range(6, 0));
    end
    chk("final_err_clear", load_err, 0);
    chk("final_done", done_seen, 8);

    rand_lk = 0; in_valid = 0;
    tickn(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/odo_sbox_bank.md
Name: odo_sbox_bank

Overview:
Multi-lane, runtime-loadable S-box bank for the Odo core. It replaces fixed, constant-table S-boxes with two table banks: one active, one shadow. A new per-epoch table streams into the shadow bank while lookups continue on the active bank, and the banks swap atomically when the load completes. It sits between the Odo round datapath (lookup side) and the epoch key-schedule loader (load side).

Parameters:
WIDTH, 6, S-box input/output width in bits; table depth DEPTH = 2**WIDTH.
LANES, 4, independent lookups per cycle, all against the same active bank.
OUT_PIPE, 0, extra output register stages (0 or 1); lookup latency = 1 + OUT_PIPE.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  lookup request valid.
in_data  in  LANES*WIDTH  lookup indices; lane k at bits [k*WIDTH +: WIDTH].
out_valid  out  1  lookup result valid.
out_data  out  LANES*WIDTH  substituted values, same lane packing.
load_start  in  1  one-cycle pulse; begins or restarts a shadow-bank load.
load_valid  in  1  load beat valid.
load_data  in  WIDTH  table entry for the current load address.
load_ready  out  1  high while in LOAD state.
load_busy  out  1  high in LOAD or SWAP state.
load_done  out  1  one-cycle pulse on swap.
load_err  out  1  sticky load error (optional feature only); cleared by load_start.
table_valid  out  1  at least one complete table has been swapped in since reset.
bank_sel  out  1  index of the active bank.

Behaviour:
- Reset (async, asserted): out_valid=0, out_data=0, load_ready=0, load_busy=0, load_done=0, load_err=0, table_valid=0, bank_sel=0, state=IDLE, load address=0.
- Bank memory contents are not reset.
- Lookup path:
  - At an edge with in_valid=1, each lane reads mem[bank_sel][index].
  - With OUT_PIPE=0: out_valid/out_data are registered and appear on the next cycle.
  - With OUT_PIPE=1: one additional register stage; latency 2.
  - Fully pipelined: one request accepted per cycle, no backpressure.
  - out_valid follows in_valid delayed by the latency.
  - out_data is forced to 0 for requests sampled while table_valid=0.
- Load FSM states: IDLE, LOAD, SWAP.
  - IDLE -> LOAD on load_start; load address cleared to 0.
  - LOAD: each edge with load_valid & load_ready writes load_data to mem[~bank_sel][addr] and increments addr.
  - LOAD: the beat written at addr = DEPTH-1 moves the FSM to SWAP.
  - LOAD: load_start restarts at addr 0; the partial data is overwritten as the new load proceeds.
  - SWAP (one cycle): bank_sel toggles, table_valid is set, load_done pulses, FSM -> IDLE.
  - The new bank_sel is visible to lookups sampled from the edge after SWAP. Lookups sampled during SWAP still use the old bank.
  - load_start in SWAP is ignored. load_start in IDLE is always accepted.
  - load_valid outside LOAD is ignored; no write occurs.
- The address counter is WIDTH+1 bits wide, so there is no wrap before the swap.
- Reset mid-load: FSM -> IDLE, bank_sel keeps its reset value 0, and the shadow contents are discarded (never swapped in).
- Lookups and shadow writes never target the same bank, so there is no read/write collision.
- Memory is dual-bank, with LANES read ports plus 1 write port. It may be implemented as replicated distributed RAM per lane.

Optional Feature:
ODO_SBOX_BANK_PERM_CHECK_EN:
- When defined:
  - A DEPTH-bit "seen" bitmap is cleared on load_start.
  - Each accepted beat sets seen[load_data].
  - A duplicate value sets load_err.
  - In SWAP, if load_err=1, bank_sel and table_valid are left unchanged and load_done still pulses. Only bijective tables become active.
- When undefined: load_err is tied to 0 and any table is swapped in.

Test Plan:
1. Reset, then lookup in_data=0x3F on all lanes -> out_valid=1 after 1 cycle, out_data=0, table_valid=0.
2. Load table f(i)=(i*5+1) mod 64, then lookup lanes {0,1,2,63} -> outputs {0x01,0x06,0x0B,0x3C}; load_done pulses once; bank_sel=1.
3. Continuous lookups of index 10 during a second load of f(i)=63-i -> out_data=0x33 on every lane until the edge after SWAP, then 0x35; no gap in out_valid.
4. After 40 load beats, pulse load_start and load a complete table g -> only g is visible after the swap. Also assert rst after 20 beats of a load -> bank_sel=0, load_busy=0, no load_done.
5. Gap load_valid every other cycle -> the swap occurs only after exactly 64 accepted beats. Hold load_valid=1 in IDLE -> no bank change.
6. With ODO_SBOX_BANK_PERM_CHECK_EN, load a table with entry 5 duplicated -> load_err=1, bank_sel unchanged, old outputs retained. Repeat with OUT_PIPE=1 -> latency 2.
